mips_debug_unit: RTL
====================

# mips_debug_unit

Host-side control block sitting directly upstream of the `mips` pipeline top. It receives command bytes over a byte-stream handshake, loads the instruction memory word by word, and holds the core in reset until the program is loaded. It runs the core free or single-steps it, and streams back PC, `result` and a cycle count. It replaces hard-coded program images and fixed simulation run lengths with a host-driven load/run/inspect loop.

## Interface
- `DATA_WIDTH`, 32: datapath width; must match `mips`.
- `IMEM_ADDR_WIDTH`, 8: instruction memory word-address width.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  host command/data byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts a byte; transfer occurs when `rx_valid & rx_ready`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  host consumes the byte; transfer occurs when `tx_valid & tx_ready`.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  IMEM_ADDR_WIDTH  word address.
- `imem_wdata`  out  DATA_WIDTH  instruction word.
- `cpu_reset`  out  1  drives `mips.reset`.
- `cpu_enable`  out  1  pipeline clock enable; all pipeline registers advance only when high.
- `cpu_halt`  in  1  `mips.halt`.
- `cpu_pc`  in  DATA_WIDTH  IF-stage PC.
- `cpu_result`  in  DATA_WIDTH  `mips.result`.

## Operation
- Values after `reset`:
  - `rx_ready`=1; `tx_valid`=0; `tx_data`=0.
  - `imem_we`=0; `imem_addr`=0; `imem_wdata`=0.
  - `cpu_reset`=1; `cpu_enable`=0.
  - cycle counter=0; state IDLE.
- `rx_ready` is high only in IDLE, LOAD_CNT and LOAD_BYTE.
- Commands are accepted in IDLE:
  - 0x4C 'L': set `cpu_reset`=1, clear the cycle counter, go to LOAD_CNT. The next byte N is the word count.
    - N=0: respond 'K' (0x4B) and return to IDLE.
    - Otherwise: LOAD_BYTE takes 4·N bytes, big-endian (first byte goes to [31:24]).
    - After each 4th byte: LOAD_WRITE, with `imem_we`=1 for exactly one cycle, `imem_addr`=word index (0..N-1, modulo 2^IMEM_ADDR_WIDTH), `imem_wdata`=assembled word.
    - After the last write: respond 'K'.
  - 0x52 'R': clear `cpu_reset`; enter RUN with `cpu_enable`=1. Remain in RUN until `cpu_halt`=1 is sampled, then drop `cpu_enable` on the next edge and respond 'H' (0x48).
  - 0x53 'S': clear `cpu_reset`; enter STEP with `cpu_enable`=1 for exactly one cycle, then respond '.' (0x2E).
  - 'R' or 'S' with `cpu_halt` already 1: no enable cycle; respond 'H'.
  - 0x44 'D': snapshot `cpu_pc`, `cpu_result` and the counter in the accept cycle. Send 12 bytes, each value big-endian, in the order PC, result, count.
  - Any other byte: respond '?' (0x3F); state unchanged otherwise.
- The cycle counter is 32-bit, increments every cycle `cpu_enable`=1, and wraps modulo 2^32.
- Responses:
  - `tx_valid`/`tx_data` are held stable until `tx_ready`.
  - The FSM returns to IDLE only after the final byte is transferred.
  - No new command is accepted while sending.
- `reset` mid-operation aborts everything:
  - Reset values are restored next edge; partial words are discarded.
  - `cpu_reset` returns to 1.

## Timing
- FSM states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, SEND.
- 'L' accepted at edge t: LOAD_CNT from t+1. The 4th byte of a word is accepted at edge k; `imem_we` is high in cycle k+1. The next byte can be accepted at edge k+2.
- 'S' accepted at edge t: `cpu_enable` is high in cycle t+1 only. `tx_valid` rises in cycle t+2.
- RUN: `cpu_halt` sampled high at edge h gives `cpu_enable`=0 from h+1 and 'H' valid from h+1.
- Simultaneous `cpu_halt` and RUN entry: the halt check precedes enabling, so there are zero enable cycles.
- Dump throughput: one byte per cycle with `tx_ready` held high; 12 cycles minimum.

## Structure
- Add to `mips_pkg.vh`:
  - command bytes CMD_LOAD/CMD_RUN/CMD_STEP/CMD_DUMP;
  - response bytes RSP_OK/RSP_HALT/RSP_STEP/RSP_ERR;
  - FSM state encodings.
- One sub-module, `debug_tx_serializer`: loads up to 12 bytes plus a length and emits them with the valid/ready handshake. All responses, single-byte or dump, go through it.

## Test plan
- Load: 'L', N=2, bytes 20 01 00 05 / 20 02 00 0A → two `imem_we` pulses; addr 0 data 0x20010005, addr 1 data 0x2002000A; then 'K'; `cpu_reset` still 1.
- After the load, 3×'S' then 'D' → three single-cycle `cpu_enable` pulses, three '.' responses; dump count bytes 00 00 00 03; PC bytes equal `cpu_pc` at 'D' accept.
- 'R' with `cpu_halt` forced high 20 cycles after enable → exactly 20 enable cycles, then 'H'; a following 'D' reports count 20 (0x14).
- Byte 0x7A in IDLE → single '?'; `tx_ready` held low 5 cycles → `tx_valid`/`tx_data` stable throughout, `rx_ready`=0.
- `reset` pulsed after the 2nd byte of a word during 'L' → no `imem_we`; `cpu_reset`=1; a new 'L' with N=0 gives 'K'.

Source files
------------

// File: rtl/mips_debug_unit_pkg.sv
// Shared constants and types for the host-side debug unit that drives the mips core.
package mips_debug_unit_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_HALT = 8'h48;
    localparam logic [7:0] RSP_STEP = 8'h2E;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    localparam int TX_MAX_BYTES = 12;

    typedef logic [TX_MAX_BYTES*8-1:0] tx_buf_t;
    typedef logic [3:0]                tx_len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP,
        ST_SEND
    } dbg_state_t;

    // Single-byte responses sit in the most significant byte, which is sent first.
    function automatic tx_buf_t single_byte(input logic [7:0] b);
        return {b, {(TX_MAX_BYTES*8-8){1'b0}}};
    endfunction

endpackage

// File: rtl/mips_debug_unit_if.sv
// Host byte streams plus instruction-memory and core-control signals of the debug unit.
interface mips_debug_unit_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]      imem_wdata;
    logic                       cpu_reset;
    logic                       cpu_enable;
    logic                       cpu_halt;
    logic [DATA_WIDTH-1:0]      cpu_pc;
    logic [DATA_WIDTH-1:0]      cpu_result;

    modport slave (
        input  rx_data, rx_valid, tx_ready, cpu_halt, cpu_pc, cpu_result,
        output rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_reset, cpu_enable
    );

    modport master (
        output rx_data, rx_valid, tx_ready, cpu_halt, cpu_pc, cpu_result,
        input  rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_reset, cpu_enable
    );
endinterface

// File: rtl/debug_tx_serializer.sv
// Emits up to 12 preloaded bytes, most significant first, over a valid/ready stream.
module debug_tx_serializer
    import mips_debug_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  tx_len_t    i_len,
    input  tx_buf_t    i_bytes,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_done
);
    tx_buf_t    r_buf;
    tx_len_t    r_left;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       w_fire;

    assign w_fire     = r_tx_valid & i_tx_ready;
    assign o_done     = w_fire && (r_left == 4'd1);
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_left     <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else if (i_load) begin
            r_tx_data  <= i_bytes[TX_MAX_BYTES*8-1 -: 8];
            r_buf      <= i_bytes << 8;
            r_left     <= i_len;
            r_tx_valid <= 1'b1;
        end else if (w_fire) begin
            // Data stays on the last byte after the final transfer; only valid drops.
            if (r_left == 4'd1) begin
                r_tx_valid <= 1'b0;
            end else begin
                r_tx_data <= r_buf[TX_MAX_BYTES*8-1 -: 8];
            end
            r_buf  <= r_buf << 8;
            r_left <= r_left - 4'd1;
        end
    end
endmodule

// File: rtl/mips_debug_unit.sv
// Host command FSM: loads instruction memory, holds/runs/steps the core and dumps its state.
module mips_debug_unit
    import mips_debug_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mips_debug_unit_if.slave  dbg
);
    dbg_state_t                 r_state;
    logic [7:0]                 r_words_left;
    logic [1:0]                 r_byte_idx;
    logic [23:0]                r_word;
    logic                       r_imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0]      r_imem_wdata;
    logic                       r_cpu_reset;
    logic                       r_cpu_enable;
    logic [31:0]                r_cycle_cnt;

    logic    w_rx_ready;
    logic    w_rx_fire;
    logic    w_tx_load;
    logic    w_tx_done;
    tx_len_t w_tx_len;
    tx_buf_t w_tx_bytes;

    assign w_rx_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD_CNT) ||
                        (r_state == ST_LOAD_BYTE);
    assign w_rx_fire  = w_rx_ready & dbg.rx_valid;

    assign dbg.rx_ready   = w_rx_ready;
    assign dbg.imem_we    = r_imem_we;
    assign dbg.imem_addr  = r_imem_addr;
    assign dbg.imem_wdata = r_imem_wdata;
    assign dbg.cpu_reset  = r_cpu_reset;
    assign dbg.cpu_enable = r_cpu_enable;

    // Every response is decided here so the serializer loads on the same edge the FSM enters SEND.
    always_comb begin
        w_tx_load  = 1'b0;
        w_tx_len   = 4'd1;
        w_tx_bytes = single_byte(RSP_ERR);
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    case (dbg.rx_data)
                        CMD_LOAD: w_tx_load = 1'b0;
                        CMD_RUN, CMD_STEP: begin
                            w_tx_load  = dbg.cpu_halt;
                            w_tx_bytes = single_byte(RSP_HALT);
                        end
                        CMD_DUMP: begin
                            w_tx_load  = 1'b1;
                            w_tx_len   = 4'd12;
                            w_tx_bytes = {32'(dbg.cpu_pc), 32'(dbg.cpu_result), r_cycle_cnt};
                        end
                        default: w_tx_load = 1'b1;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                w_tx_load  = w_rx_fire && (dbg.rx_data == 8'd0);
                w_tx_bytes = single_byte(RSP_OK);
            end
            ST_LOAD_WRITE: begin
                w_tx_load  = (r_words_left == 8'd1);
                w_tx_bytes = single_byte(RSP_OK);
            end
            ST_RUN: begin
                w_tx_load  = dbg.cpu_halt;
                w_tx_bytes = single_byte(RSP_HALT);
            end
            ST_STEP: begin
                w_tx_load  = 1'b1;
                w_tx_bytes = single_byte(RSP_STEP);
            end
            default: w_tx_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_words_left <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_cpu_enable <= 1'b0;
            r_cycle_cnt  <= 32'd0;
        end else begin
            if (r_cpu_enable) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        case (dbg.rx_data)
                            CMD_LOAD: begin
                                r_cpu_reset <= 1'b1;
                                r_cycle_cnt <= 32'd0;
                                r_state     <= ST_LOAD_CNT;
                            end
                            CMD_RUN, CMD_STEP: begin
                                r_cpu_reset <= 1'b0;
                                if (!dbg.cpu_halt) begin
                                    r_cpu_enable <= 1'b1;
                                    r_state <= (dbg.rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                                end
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD_CNT: begin
                    if (w_rx_fire && (dbg.rx_data != 8'd0)) begin
                        r_words_left <= dbg.rx_data;
                        r_byte_idx   <= 2'd0;
                        r_imem_addr  <= '0;
                        r_state      <= ST_LOAD_BYTE;
                    end
                end
                ST_LOAD_BYTE: begin
                    if (w_rx_fire) begin
                        r_word     <= {r_word[15:0], dbg.rx_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_wdata <= DATA_WIDTH'({r_word, dbg.rx_data});
                            r_state      <= ST_LOAD_WRITE;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    r_imem_we    <= 1'b0;
                    r_imem_addr  <= r_imem_addr + 1'b1;
                    r_words_left <= r_words_left - 8'd1;
                    r_state      <= ST_LOAD_BYTE;
                end
                ST_RUN: begin
                    if (dbg.cpu_halt) begin
                        r_cpu_enable <= 1'b0;
                    end
                end
                ST_STEP: r_cpu_enable <= 1'b0;
                ST_SEND: begin
                    if (w_tx_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_tx_load) begin
                r_state <= ST_SEND;
            end
        end
    end

    debug_tx_serializer u_tx (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tx_load),
        .i_len      (w_tx_len),
        .i_bytes    (w_tx_bytes),
        .o_tx_data  (dbg.tx_data),
        .o_tx_valid (dbg.tx_valid),
        .i_tx_ready (dbg.tx_ready),
        .o_done     (w_tx_done)
    );
endmodule
